mem: RTL and testbench

- MEM stage of the 5-stage pipeline; sits between EXE and WB.
- Consumes the EXE->MEM bus, performs loads and stores against the data memory through a req/gnt/rvalid handshake, and aligns sub-word data.
- Registers the MEM->WB bus {wb_wdest, wb_we, mem_result, pc} together with its WB valid bit, which drive the WB stage.

---
 rtl/mem_pkg.sv | 53 +++++
 rtl/mem_align.sv | 57 +++++
 rtl/mem.sv | 138 +++++++++++++
 tb/tb_mem.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage:
// the EXE->MEM and MEM->WB bus layouts, access size codes and FSM states.
package mem_pkg;

    localparam int EXE2MEM_BUS_SIZE = 107;
    localparam int MEM2WB_BUS_SIZE  = 70;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } mem_state_e;

    typedef struct packed {
        logic      ld;
        logic      st;
        mem_size_e size;
        logic      uns;
    } mem_ctl_t;

    typedef struct packed {
        mem_ctl_t    mem_ctl;
        logic [31:0] store_data;
        logic [31:0] exe_result;
        logic [4:0]  rf_wdest;
        logic        rf_we;
        logic [31:0] pc;
    } exe2mem_bus_t;

    typedef struct packed {
        logic [4:0]  wb_wdest;
        logic        wb_we;
        logic [31:0] mem_result;
        logic [31:0] pc;
    } mem2wb_bus_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr);
        case (size)
            MEM_H:   return addr[0];
            MEM_W:   return addr != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Sub-word alignment for the MEM stage: load byte/half extraction with
// sign or zero extension, and store byte-enable / data lane replication.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  mem_size_e   size,
    input  logic        uns,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] load_data,
    output logic [3:0]  store_be,
    output logic [31:0] store_wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (size)
            MEM_B:   load_data = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            MEM_H:   load_data = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = rdata;
        endcase
    end

    // Stores put the datum on every lane; the byte enables pick the live one.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = store_data;
        case (size)
            MEM_B: begin
                store_be    = 4'b0001 << addr;
                store_wdata = {4{store_data[7:0]}};
            end
            MEM_H: begin
                store_be    = 4'b0011 << addr;
                store_wdata = {2{store_data[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem.sv
// MEM stage of the 5-stage pipeline: issues loads/stores over a req/gnt/rvalid
// data-memory handshake and registers the MEM->WB bus.
module mem
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [EXE2MEM_BUS_SIZE-1:0] exe2mem_bus_ri,
    input  logic                       ctl_mem_valid_i,
    input  logic                       ctl_wb_allow_in_i,
    output logic                       ctl_mem_over_o,
    output logic                       ctl_mem_allow_in_o,
    output logic [4:0]                 ctl_mem_dest_o,
    output logic                       ctl_mem_ale_o,
    output logic [MEM2WB_BUS_SIZE-1:0] mem2wb_bus_ro,
    output logic                       ctl_wb_valid_o,
    output logic                       dm_req_o,
    output logic [3:0]                 dm_we_o,
    output logic [AW-1:0]              dm_addr_o,
    output logic [DW-1:0]              dm_wdata_o,
    input  logic                       dm_gnt_i,
    input  logic                       dm_rvalid_i,
    input  logic [DW-1:0]              dm_rdata_i
);

    exe2mem_bus_t bus;
    mem_ctl_t     ctl;
    mem2wb_bus_t  wb_next;
    mem_state_e   state;

    logic        misaligned;
    logic        mem_op;
    logic        accept;
    logic        wb_we;
    logic [31:0] load_q;
    logic [31:0] load_data;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;

    assign bus = exe2mem_bus_t'(exe2mem_bus_ri);
    assign ctl = bus.mem_ctl;

    // A misaligned access never reaches memory; it retires like an ALU op.
    assign misaligned = (ctl.ld | ctl.st) & is_misaligned(ctl.size, bus.exe_result[1:0]);
    assign mem_op     = (ctl.ld | ctl.st) & ~misaligned;

    assign ctl_mem_over_o     = ((state == ST_IDLE) & ~mem_op) | (state == ST_DONE);
    assign accept             = ctl_mem_valid_i & ctl_mem_over_o & ctl_wb_allow_in_i;
    assign ctl_mem_allow_in_o = ~ctl_mem_valid_i | accept;
    assign ctl_mem_dest_o     = bus.rf_wdest & {5{ctl_mem_valid_i}};

    mem_align u_align (
        .addr        (bus.exe_result[1:0]),
        .size        (ctl.size),
        .uns         (ctl.uns),
        .store_data  (bus.store_data),
        .rdata       (dm_rdata_i),
        .load_data   (load_data),
        .store_be    (store_be),
        .store_wdata (store_wdata)
    );

    assign dm_addr_o  = AW'({bus.exe_result[31:2], 2'b00});
    assign dm_we_o    = ctl.st ? store_be : 4'b0000;
    assign dm_wdata_o = store_wdata;

    assign wb_we            = bus.rf_we & ~ctl.st & ~misaligned;
    assign wb_next.wb_wdest = bus.rf_wdest;
    assign wb_next.wb_we    = wb_we;
    assign wb_next.mem_result = (ctl.ld & ~misaligned) ? load_q : bus.exe_result;
    assign wb_next.pc       = bus.pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            dm_req_o <= 1'b0;
            load_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl_mem_valid_i && mem_op) begin
                        state    <= ST_REQ;
                        dm_req_o <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (dm_gnt_i) begin
                        dm_req_o <= 1'b0;
                        if (ctl.st) begin
                            state <= ST_DONE;
                        end else if (dm_rvalid_i) begin
                            load_q <= load_data;
                            state  <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dm_rvalid_i) begin
                        load_q <= load_data;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (accept) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    dm_req_o <= 1'b0;
                end
            endcase
        end
    end

    // WB valid stays up while WB stalls, and drops once WB drains it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem2wb_bus_ro  <= '0;
            ctl_wb_valid_o <= 1'b0;
            ctl_mem_ale_o  <= 1'b0;
        end else begin
            ctl_mem_ale_o <= accept & misaligned;
            if (accept) begin
                mem2wb_bus_ro  <= wb_next;
                ctl_wb_valid_o <= 1'b1;
            end else if (ctl_wb_allow_in_i) begin
                ctl_wb_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for the MEM stage: directed cases plus randomized
// ALU/load/store traffic checked against an arithmetic reference model.
module tb_mem;

    logic         clk = 1'b0;
    logic         resetn;
    logic [106:0] exe2mem_bus_ri;
    logic         ctl_mem_valid_i;
    logic         ctl_wb_allow_in_i;
    logic         ctl_mem_over_o;
    logic         ctl_mem_allow_in_o;
    logic [4:0]   ctl_mem_dest_o;
    logic         ctl_mem_ale_o;
    logic [69:0]  mem2wb_bus_ro;
    logic         ctl_wb_valid_o;
    logic         dm_req_o;
    logic [3:0]   dm_we_o;
    logic [31:0]  dm_addr_o;
    logic [31:0]  dm_wdata_o;
    logic         dm_gnt_i;
    logic         dm_rvalid_i;
    logic [31:0]  dm_rdata_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem #(.AW(32), .DW(32)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .exe2mem_bus_ri     (exe2mem_bus_ri),
        .ctl_mem_valid_i    (ctl_mem_valid_i),
        .ctl_wb_allow_in_i  (ctl_wb_allow_in_i),
        .ctl_mem_over_o     (ctl_mem_over_o),
        .ctl_mem_allow_in_o (ctl_mem_allow_in_o),
        .ctl_mem_dest_o     (ctl_mem_dest_o),
        .ctl_mem_ale_o      (ctl_mem_ale_o),
        .mem2wb_bus_ro      (mem2wb_bus_ro),
        .ctl_wb_valid_o     (ctl_wb_valid_o),
        .dm_req_o           (dm_req_o),
        .dm_we_o            (dm_we_o),
        .dm_addr_o          (dm_addr_o),
        .dm_wdata_o         (dm_wdata_o),
        .dm_gnt_i           (dm_gnt_i),
        .dm_rvalid_i        (dm_rvalid_i),
        .dm_rdata_i         (dm_rdata_i)
    );

    task automatic checkOutput(input string tag, input logic [69:0] observed, input logic [69:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit modelMisaligned(input int size, input logic [31:0] addr);
        if (size == 1) return (addr % 2) != 0;
        if (size == 2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelLoad(input int size, input bit uns, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        if (size == 0) begin
            v = (rdata >> (8 * (addr % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 1) begin
            v = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [3:0] modelBe(input int size, input logic [31:0] addr);
        if (size == 0) return 4'(1 << (addr % 4));
        if (size == 1) return 4'(3 << (addr % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] modelWdata(input int size, input logic [31:0] d);
        if (size == 0) return (d & 32'hFF) * 32'h01010101;
        if (size == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // One instruction through MEM: gnt_dly idle REQ cycles before gnt, rv_dly cycles
    // from gnt to rvalid (0 = same cycle), hold = DONE cycles with WB stalled.
    task automatic applyStimulus(input bit ld, input bit st, input int size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input logic [31:0] pc,
                                 input bit rf_we, input logic [4:0] dest,
                                 input int gnt_dly, input int rv_dly, input int hold);
        bit          mis;
        bit          memop;
        bit          exp_we;
        logic [31:0] exp_res;
        mis     = (ld || st) && modelMisaligned(size, addr);
        memop   = (ld || st) && !mis;
        exp_we  = rf_we && !st && !mis;
        exp_res = (ld && !mis) ? modelLoad(size, uns, addr, rdata) : addr;

        exe2mem_bus_ri    = {ld, st, 2'(size), uns, sdata, addr, dest, rf_we, pc};
        ctl_mem_valid_i   = 1'b1;
        ctl_wb_allow_in_i = (hold == 0);
        dm_gnt_i          = 1'b0;
        dm_rvalid_i       = 1'b0;
        dm_rdata_i        = $urandom;
        #1;
        checkOutput("dest", 70'(ctl_mem_dest_o), 70'(dest));
        if (memop) begin
            checkOutput("idle_over", 70'(ctl_mem_over_o), 70'(0));
            checkOutput("idle_req", 70'(dm_req_o), 70'(0));
            step();
            for (int k = 0; k <= gnt_dly; k++) begin
                checkOutput("req", 70'(dm_req_o), 70'(1));
                checkOutput("addr", 70'(dm_addr_o), 70'(addr & 32'hFFFFFFFC));
                checkOutput("we", 70'(dm_we_o), 70'(st ? modelBe(size, addr) : 4'h0));
                if (st) checkOutput("wdata", 70'(dm_wdata_o), 70'(modelWdata(size, sdata)));
                checkOutput("req_over", 70'(ctl_mem_over_o), 70'(0));
                if (k == gnt_dly) begin
                    dm_gnt_i    = 1'b1;
                    dm_rvalid_i = ld && (rv_dly == 0);
                    dm_rdata_i  = rdata;
                end else begin
                    dm_rvalid_i = 1'($urandom_range(0, 1));
                    dm_rdata_i  = $urandom;
                end
                step();
            end
            dm_gnt_i    = 1'b0;
            dm_rvalid_i = 1'b0;
            if (ld && rv_dly > 0) begin
                for (int k = 1; k < rv_dly; k++) begin
                    checkOutput("wait_req", 70'(dm_req_o), 70'(0));
                    checkOutput("wait_over", 70'(ctl_mem_over_o), 70'(0));
                    step();
                end
                dm_rvalid_i = 1'b1;
                dm_rdata_i  = rdata;
                step();
            end
        end
        // Late rvalid with junk data while waiting for WB must be ignored.
        dm_rvalid_i = 1'b1;
        dm_rdata_i  = ~rdata;
        for (int h = 0; h < hold; h++) begin
            #1;
            checkOutput("hold_over", 70'(ctl_mem_over_o), 70'(1));
            checkOutput("hold_allow", 70'(ctl_mem_allow_in_o), 70'(0));
            step();
        end
        ctl_wb_allow_in_i = 1'b1;
        #1;
        checkOutput("over", 70'(ctl_mem_over_o), 70'(1));
        checkOutput("allow_in", 70'(ctl_mem_allow_in_o), 70'(1));
        checkOutput("done_req", 70'(dm_req_o), 70'(0));
        step();
        ctl_mem_valid_i = 1'b0;
        dm_rvalid_i     = 1'b0;
        checkOutput("wb_bus", mem2wb_bus_ro, {dest, exp_we, exp_res, pc});
        checkOutput("wb_valid", 70'(ctl_wb_valid_o), 70'(1));
        checkOutput("ale", 70'(ctl_mem_ale_o), 70'(mis));
    endtask

    initial begin
        resetn            = 1'b0;
        exe2mem_bus_ri    = '0;
        ctl_mem_valid_i   = 1'b0;
        ctl_wb_allow_in_i = 1'b1;
        dm_gnt_i          = 1'b0;
        dm_rvalid_i       = 1'b0;
        dm_rdata_i        = '0;
        #2;
        checkOutput("rst_req", 70'(dm_req_o), 70'(0));
        checkOutput("rst_bus", mem2wb_bus_ro, 70'(0));
        checkOutput("rst_valid", 70'(ctl_wb_valid_o), 70'(0));
        checkOutput("rst_ale", 70'(ctl_mem_ale_o), 70'(0));
        step();
        step();
        resetn = 1'b1;
        step();

        $display("[TB] directed cases");
        applyStimulus(0, 0, 0, 0, 32'h1234, 32'h0, 32'h0, 32'h400, 1, 5'd3, 0, 0, 0);
        applyStimulus(0, 1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 32'h404, 1, 5'd5, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 32'h203, 32'h0, 32'h80112233, 32'h408, 1, 5'd6, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 32'h203, 32'h0, 32'h80112233, 32'h40C, 1, 5'd7, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 32'h202, 32'h0, 32'hBEEF0000, 32'h410, 1, 5'd8, 3, 2, 0);
        applyStimulus(1, 0, 2, 0, 32'h1002, 32'h0, 32'h0, 32'h414, 1, 5'd9, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 32'h1001, 32'hCAFE, 32'h0, 32'h418, 0, 5'd10, 0, 0, 0);
        step();
        checkOutput("ale_pulse_end", 70'(ctl_mem_ale_o), 70'(0));
        checkOutput("wb_valid_drop", 70'(ctl_wb_valid_o), 70'(0));
        applyStimulus(1, 0, 1, 0, 32'h806, 32'h0, 32'h9ABC1234, 32'h41C, 1, 5'd11, 1, 1, 2);
        applyStimulus(0, 1, 0, 0, 32'h905, 32'h77, 32'h0, 32'h420, 1, 5'd12, 2, 0, 1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            applyStimulus(kind == 1, kind == 2, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                          $urandom, $urandom, $urandom, $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("[TB] reset during WAIT");
        exe2mem_bus_ri  = {1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h300, 5'd4, 1'b1, 32'h500};
        ctl_mem_valid_i = 1'b1;
        step();
        dm_gnt_i = 1'b1;
        step();
        dm_gnt_i = 1'b0;
        resetn   = 1'b0;
        #1;
        checkOutput("mid_rst_req", 70'(dm_req_o), 70'(0));
        checkOutput("mid_rst_valid", 70'(ctl_wb_valid_o), 70'(0));
        checkOutput("mid_rst_over", 70'(ctl_mem_over_o), 70'(0));
        ctl_mem_valid_i = 1'b0;
        step();
        resetn      = 1'b1;
        dm_rvalid_i = 1'b1;
        dm_rdata_i  = 32'h55AA55AA;
        step();
        dm_rvalid_i = 1'b0;
        checkOutput("late_rv_req", 70'(dm_req_o), 70'(0));
        checkOutput("late_rv_valid", 70'(ctl_wb_valid_o), 70'(0));
        applyStimulus(0, 0, 0, 0, 32'hABCD, 32'h0, 32'h0, 32'h504, 1, 5'd13, 0, 0, 0);
        applyStimulus(1, 0, 2, 0, 32'h300, 32'h0, 32'h13579BDF, 32'h508, 1, 5'd14, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
